// File: rtl/div_issue_queue.sv
// Issue queue for the divide unit: collapsing age-ordered queue with CDB snoop
// and oldest-ready selection feeding a registered issue packet.
module div_issue_queue #(
  parameter  int DATA_W = 32,
  parameter  int TAG_W  = 6,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_en,
  input  logic [DATA_W-1:0] dispatch_rs_data,
  input  logic [TAG_W-1:0]  dispatch_rs_tag,
  input  logic              dispatch_rs_valid,
  input  logic [DATA_W-1:0] dispatch_rt_data,
  input  logic [TAG_W-1:0]  dispatch_rt_tag,
  input  logic              dispatch_rt_valid,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  output logic              div_queue_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              issue_ready,
  input  logic              issue_grant,
  output logic              issueblk_done,
  output logic [DATA_W-1:0] issueque_rs_data,
  output logic [DATA_W-1:0] issueque_rt_data,
  output logic [TAG_W-1:0]  issueque_rd_tag,
  output logic [CNT_W-1:0]  div_queue_count
);

  typedef struct packed {
    logic              valid;
    logic              rs_rdy;
    logic [TAG_W-1:0]  rs_tag;
    logic [DATA_W-1:0] rs_data;
    logic              rt_rdy;
    logic [TAG_W-1:0]  rt_tag;
    logic [DATA_W-1:0] rt_data;
    logic [TAG_W-1:0]  rd_tag;
  } entry_t;

  entry_t            q     [DEPTH];
  entry_t            snoop [DEPTH+1];
  entry_t            nxt   [DEPTH];
  entry_t            new_e;
  entry_t            sel_e;
  logic [CNT_W-1:0]  sel;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              fire;
  logic              accept;
  logic              rs_bypass;
  logic              rt_bypass;

  // Selection looks at registered state only, so a snoop wake-up becomes
  // selectable the cycle after the broadcast.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    issue_ready = 1'b0;
    sel         = '0;
    sel_e       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!issue_ready && q[i].valid && q[i].rs_rdy && q[i].rt_rdy) begin
        issue_ready = 1'b1;
        sel         = CNT_W'(i);
        sel_e       = q[i];
      end
    end
  end

  assign fire   = issue_ready & issue_grant;
  assign accept = dispatch_en & ~full_q & ~flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snoop[i] = q[i];
      if (cdb_valid && q[i].valid) begin
        if (!q[i].rs_rdy && q[i].rs_tag == cdb_tag) begin
          snoop[i].rs_rdy  = 1'b1;
          snoop[i].rs_data = cdb_data;
        end
        if (!q[i].rt_rdy && q[i].rt_tag == cdb_tag) begin
          snoop[i].rt_rdy  = 1'b1;
          snoop[i].rt_data = cdb_data;
        end
      end
    end
    // Empty slot shifted into the top position on compaction.
    snoop[DEPTH] = '0;
  end

  // Operands broadcast on the dispatch cycle are captured directly.
  assign rs_bypass = ~dispatch_rs_valid & cdb_valid & (dispatch_rs_tag == cdb_tag);
  assign rt_bypass = ~dispatch_rt_valid & cdb_valid & (dispatch_rt_tag == cdb_tag);

  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.rs_rdy  = dispatch_rs_valid | rs_bypass;
    new_e.rs_tag  = dispatch_rs_tag;
    new_e.rs_data = rs_bypass ? cdb_data : dispatch_rs_data;
    new_e.rt_rdy  = dispatch_rt_valid | rt_bypass;
    new_e.rt_tag  = dispatch_rt_tag;
    new_e.rt_data = rt_bypass ? cdb_data : dispatch_rt_data;
    new_e.rd_tag  = dispatch_rd_tag;
  end

  // Entries are contiguous from index 0, so after removing the issued entry
  // the first free slot is simply the post-issue occupancy.
  assign wr_idx    = count_q - CNT_W'(fire);
  assign count_nxt = count_q + CNT_W'(accept) - CNT_W'(fire);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = (fire && CNT_W'(i) >= sel) ? snoop[i+1] : snoop[i];
      if (accept && CNT_W'(i) == wr_idx) begin
        nxt[i] = new_e;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the queue is a handful of flops rather than a RAM, so the whole
    // array is reset; clearing only valid would leave stale fields visible.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count_q          <= '0;
      full_q           <= 1'b0;
      issueblk_done    <= 1'b0;
      issueque_rs_data <= '0;
      issueque_rt_data <= '0;
      issueque_rd_tag  <= '0;
    end else if (flush) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count_q          <= '0;
      full_q           <= 1'b0;
      issueblk_done    <= 1'b0;
      issueque_rs_data <= '0;
      issueque_rt_data <= '0;
      issueque_rd_tag  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
      count_q          <= count_nxt;
      full_q           <= (count_nxt == CNT_W'(DEPTH));
      issueblk_done    <= fire;
      issueque_rs_data <= fire ? sel_e.rs_data : '0;
      issueque_rt_data <= fire ? sel_e.rt_data : '0;
      issueque_rd_tag  <= fire ? sel_e.rd_tag  : '0;
    end
  end

  assign div_queue_full  = full_q;
  assign div_queue_count = count_q;

endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
Issue queue for the divide execution unit. It sits between dispatch and the divider.
- Holds up to DEPTH divide instructions and captures missing source operands by snooping the CDB.
- Asks the issue arbiter for a slot and, once granted, sends the oldest ready entry to the divider as one registered issue packet.
- The issue packet holds issueblk_done, rs data, rt data and rd tag. This is the packet the divider latches and returns 7 cycles later.

Parameters:
DATA_W, 32, operand/result width
TAG_W, 6, physical register tag width
DEPTH, 4, queue entries (power of two not required, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of all entries (branch mispredict)
dispatch_en  in  1  write a new divide instruction
dispatch_rs_data  in  DATA_W  rs value (valid when dispatch_rs_valid)
dispatch_rs_tag  in  TAG_W  rs producer tag
dispatch_rs_valid  in  1  rs value already available
dispatch_rt_data  in  DATA_W  rt value
dispatch_rt_tag  in  TAG_W  rt producer tag
dispatch_rt_valid  in  1  rt value already available
dispatch_rd_tag  in  TAG_W  destination tag
div_queue_full  out  1  no free entry; dispatch must stall
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB broadcast tag
cdb_data  in  DATA_W  CDB broadcast data
issue_ready  out  1  at least one entry has both operands ready (combinational)
issue_grant  in  1  arbiter grant for this cycle
issueblk_done  out  1  issue packet valid, one-cycle pulse
issueque_rs_data  out  DATA_W  dividend
issueque_rt_data  out  DATA_W  divisor
issueque_rd_tag  out  TAG_W  destination tag
div_queue_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:

Reset (async, rst=1)
- All entry valid bits = 0, count = 0.
- issueblk_done = 0; issueque_rs_data, issueque_rt_data, issueque_rd_tag = 0.
- div_queue_full = 0, issue_ready = 0.
- Reset mid-operation drops all entries and any pending packet immediately.

Storage
- Collapsing queue: index 0 is the oldest entry.
- Each entry holds: valid, rs_rdy, rs_tag, rs_data, rt_rdy, rt_tag, rt_data, rd_tag.

CDB snoop
- Every cycle, for each valid entry with rs_rdy=0 and rs_tag==cdb_tag while cdb_valid=1: set rs_rdy=1 and rs_data=cdb_data. Same rule for rt.
- An entry that becomes ready this way is selectable from the next cycle.

Dispatch
- Accepted when dispatch_en=1, div_queue_full=0 and flush=0.
- Written at the first free slot after any same-cycle issue compaction.
- CDB bypass on the dispatch cycle: if an operand is not valid, cdb_valid=1 and its tag equals cdb_tag, the entry stores cdb_data with rdy=1.
- dispatch_en while full is ignored; no state change.

Full flag
- div_queue_full = (count==DEPTH), registered from the updated count.
- A same-cycle issue does not unblock a dispatch in that cycle.

Select and issue
- issue_ready = OR over entries of (valid & rs_rdy & rt_rdy).
- Selected entry = lowest-index ready entry (oldest first).
- When issue_ready=1 and issue_grant=1, on the next edge:
  - issueblk_done <= 1 and the data/tag outputs <= selected entry fields.
  - The selected entry is removed; entries above it shift down one place, keeping their snoop updates from the same cycle.
- Otherwise, on the next edge: issueblk_done <= 0 and the data/tag outputs <= 0.
- Exactly one issue per cycle; back-to-back grants are allowed.
- issue_grant while issue_ready=0 is ignored.
- Latency: dispatch with both operands valid -> issue_ready in the next cycle -> issueblk_done one cycle after the grant.

Flush
- Synchronous, highest priority over dispatch, snoop and issue.
- Next edge: all entries invalid, count=0, issueblk_done=0 and outputs=0.

Count
- count_next = count + dispatch_accepted - issue_fired.

Arithmetic
- No arithmetic on operands. Divide-by-zero is passed through untouched.

Test Plan:
- Reset then dispatch rs=100 (valid), rt=7 (valid), rd_tag=5; hold grant=1 -> issue_ready=1 one cycle after dispatch; next cycle issueblk_done=1, rs=100, rt=7, tag=5, for one cycle; count returns to 0.
- Dispatch rt pending on tag 12, grant=1 held -> no issue; cdb_valid=1, tag=12, data=4 -> issue_ready the next cycle, issueblk_done one cycle later with rt_data=4.
- Dispatch on the same cycle as a CDB broadcast of the pending tag (tag 9, data 3) -> entry captures 3; issues without waiting for another broadcast.
- Fill 4 entries, each waiting on a distinct tag -> div_queue_full=1; a 5th dispatch is dropped (count stays 4); wake entry 2 then entry 0 -> issue order follows age: entry 0 first once both are ready.
- Two ready entries with grant held -> issueblk_done on two consecutive cycles, oldest first; count decrements by 1 each cycle.
- Flush asserted alongside dispatch_en and grant with 3 entries -> next cycle count=0, issueblk_done=0, div_queue_full=0. Separately: assert rst mid-issue -> outputs 0 immediately.
